// File: rtl/usart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// usart_rx_frame_ctrl : oversampled USART receiver, majority vote, RX FIFO
// Rev 1.0
// ============================================================================
module usart_rx_frame_ctrl #(
   parameter int DATA_W     = 9,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 2,
   parameter int LVL_W      = 2
) (
   input  logic              i_fosk,
   input  logic              i_rst_n,
   input  logic              i_rxen,
   input  logic              i_rxd,
   input  logic              i_sample_en,
   input  logic [2:0]        i_ucsz,
   input  logic [1:0]        i_upm,
   input  logic              i_rd,
   output logic [DATA_W-1:0] o_data,
   output logic              o_fe,
   output logic              o_pe,
   output logic              o_dor,
   output logic              o_valid,
   output logic [LVL_W-1:0]  o_level,
   output logic              o_busy
);
   localparam int S_W   = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_W);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = DATA_W + 2;
   localparam logic [S_W-1:0] S_V0  = S_W'(OVERSAMPLE/2 - 1);
   localparam logic [S_W-1:0] S_V1  = S_W'(OVERSAMPLE/2);
   localparam logic [S_W-1:0] S_RES = S_W'(OVERSAMPLE/2 + 1);
   localparam logic [S_W-1:0] S_END = S_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;

   logic [1:0]        sync;
   logic              rxs;
   logic [S_W-1:0]    s;
   logic              v0, v1, voted;
   logic              resolve, bit_end;
   logic [IDX_W-1:0]  bit_idx, last_idx;
   logic [DATA_W-1:0] shreg;
   logic              par, pe, par_en, par_odd;
   logic              push;

   function automatic logic [IDX_W-1:0] last_of(input logic [2:0] ucsz);
      case (ucsz)
         3'b000:  last_of = IDX_W'(4);
         3'b001:  last_of = IDX_W'(5);
         3'b010:  last_of = IDX_W'(6);
         3'b111:  last_of = IDX_W'(8);
         default: last_of = IDX_W'(7);
      endcase
   endfunction

   always_ff @(posedge i_fosk or negedge i_rst_n) begin
      if (!i_rst_n) sync <= 2'b11;
      else          sync <= {sync[0], i_rxd};
   end
   assign rxs = sync[1];

   assign voted   = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
   assign resolve = i_sample_en && (s == S_RES);
   assign bit_end = i_sample_en && (s == S_END);

   always_ff @(posedge i_fosk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      push     = 1'b0;
      if (!i_rxen) begin
         state_nx = IDLE;
      end else if (i_sample_en) begin
         case (state)
            IDLE:    if (!rxs) state_nx = START;
            START:   if (resolve && voted) state_nx = IDLE;
                     else if (bit_end)     state_nx = DATA;
            DATA:    if (bit_end && bit_idx == last_idx)
                        state_nx = par_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:    if (resolve) begin
                        state_nx = IDLE;
                        push     = 1'b1;
                     end
            default: state_nx = IDLE;
         endcase
      end
   end

   // The detecting tick counts as s=0, so the counter resumes at 1.
   always_ff @(posedge i_fosk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s <= '0; v0 <= 1'b1; v1 <= 1'b1;
         bit_idx <= '0; last_idx <= IDX_W'(7);
         shreg <= '0; par <= 1'b0; pe <= 1'b0;
         par_en <= 1'b0; par_odd <= 1'b0;
      end else if (i_rxen && i_sample_en) begin
         if (state == IDLE) begin
            if (!rxs) begin
               s        <= S_W'(1);
               bit_idx  <= '0;
               last_idx <= last_of(i_ucsz);
               shreg    <= '0;
               par      <= 1'b0;
               pe       <= 1'b0;
               par_en   <= i_upm[1];
               par_odd  <= i_upm[0];
            end
         end else begin
            s <= (s == S_END) ? '0 : s + S_W'(1);
            if (s == S_V0) v0 <= rxs;
            if (s == S_V1) v1 <= rxs;
            if (s == S_RES && state == DATA) begin
               shreg[bit_idx] <= voted;
               par            <= par ^ voted;
            end
            if (s == S_RES && state == PARITY) pe <= par ^ voted ^ par_odd;
            if (s == S_END && state == DATA) bit_idx <= bit_idx + IDX_W'(1);
         end
      end
   end

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [LVL_W-1:0] wr_cnt, rd_cnt, level;
   logic [ENT_W-1:0] head;
   logic             valid, full, pop, wr_ok, ovr;

   assign level = wr_cnt - rd_cnt;
   assign valid = (level != '0);
   assign full  = (level == LVL_W'(FIFO_DEPTH));
   assign pop   = i_rd && valid;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_ok = push && (!full || pop);
   assign ovr   = push && full && !pop;

   always_ff @(posedge i_fosk) begin
      if (wr_ok) mem[wr_cnt[PTR_W-1:0]] <= {shreg, ~voted, pe};
   end

   always_ff @(posedge i_fosk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_cnt <= '0; rd_cnt <= '0; o_dor <= 1'b0;
      end else if (!i_rxen) begin
         wr_cnt <= '0; rd_cnt <= '0; o_dor <= 1'b0;
      end else begin
         if (wr_ok) wr_cnt <= wr_cnt + LVL_W'(1);
         if (pop)   rd_cnt <= rd_cnt + LVL_W'(1);
         if (ovr)      o_dor <= 1'b1;
         else if (pop) o_dor <= 1'b0;
      end
   end

   assign head    = mem[rd_cnt[PTR_W-1:0]];
   assign o_data  = valid ? head[ENT_W-1:2] : '0;
   assign o_fe    = valid & head[1];
   assign o_pe    = valid & head[0];
   assign o_valid = valid;
   assign o_level = level;
   assign o_busy  = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_usart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_usart_rx_frame_ctrl : scoreboard bench for usart_rx_frame_ctrl
// Rev 1.0
// ============================================================================
module tb_usart_rx_frame_ctrl;
   localparam int OS = 16;

   logic       fosk = 1'b0, rst_n = 1'b0, rxen = 1'b0, rxd = 1'b1;
   logic       sample_en = 1'b0, rd = 1'b0;
   logic [2:0] ucsz = 3'b011;
   logic [1:0] upm  = 2'b00;
   logic [8:0] dout;
   logic       fe, pe, dor, valid, busy;
   logic [1:0] level;

   int          n_vec = 0;
   int          n_err = 0;
   logic [10:0] sb [$];
   logic [10:0] exp_e;

   usart_rx_frame_ctrl dut (
      .i_fosk(fosk), .i_rst_n(rst_n), .i_rxen(rxen), .i_rxd(rxd),
      .i_sample_en(sample_en), .i_ucsz(ucsz), .i_upm(upm), .i_rd(rd),
      .o_data(dout), .o_fe(fe), .o_pe(pe), .o_dor(dor), .o_valid(valid),
      .o_level(level), .o_busy(busy)
   );

   always #5 fosk = ~fosk;

   initial begin : tick_gen
      forever begin
         repeat (3) @(negedge fosk);
         sample_en = 1'b1;
         @(negedge fosk);
         sample_en = 1'b0;
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      do @(posedge fosk); while (sample_en !== 1'b1);
      #1;
   endtask

   task automatic idle_ticks(input int n);
      rxd = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   // glitch: data bit index whose middle vote sample is inverted (-1 = none)
   task automatic send_frame(input logic [8:0] d, input int nb, input bit par_en,
                             input bit par_bit, input bit stop_bit, input int glitch);
      logic seq [$];
      int   gk;
      gk = (glitch < 0) ? -1 : glitch + 1;
      seq.push_back(1'b0);
      for (int i = 0; i < nb; i++) seq.push_back(d[i]);
      if (par_en) seq.push_back(par_bit);
      seq.push_back(stop_bit);
      tick();
      foreach (seq[k]) begin
         for (int j = 0; j < OS; j++) begin
            rxd = (k == gk && j == OS/2) ? ~seq[k] : seq[k];
            tick();
         end
      end
      rxd = 1'b1;
   endtask

   task automatic pop_fifo();
      @(negedge fosk); rd = 1'b1;
      @(negedge fosk); rd = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge fosk);
      n_vec++;
      if ({dout, fe, pe, dor, valid, level, busy} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected 0000", {dout, fe, pe, dor, valid, level, busy});
      end
      rst_n = 1'b1;
      rxen  = 1'b1;
      idle_ticks(4);
   endtask

   task automatic test_8n1();
      ucsz = 3'b011; upm = 2'b00;
      send_frame(9'h0A5, 8, 0, 0, 1, -1);
      sb.push_back({9'h0A5, 1'b0, 1'b0});
      @(negedge fosk);
      n_vec++;
      if (level !== 2'(sb.size())) begin
         n_err++; $display("FAIL 8n1_level: got %0d expected %0d", level, sb.size());
      end
      exp_e = sb.pop_front();
      n_vec++;
      if ({dout, fe, pe} !== exp_e) begin
         n_err++; $display("FAIL 8n1_head: got %h expected %h", {dout, fe, pe}, exp_e);
      end
      pop_fifo();
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++; $display("FAIL 8n1_valid_after_read: got %b expected 0", valid);
      end
   endtask

   task automatic test_parity9();
      logic p;
      ucsz = 3'b111; upm = 2'b10;
      p = ^(9'h1C3);
      send_frame(9'h1C3, 9, 1, ~p, 1, -1);
      sb.push_back({9'h1C3, 1'b0, 1'b1});
      send_frame(9'h1C3, 9, 1, p, 1, -1);
      sb.push_back({9'h1C3, 1'b0, 1'b0});
      for (int i = 0; i < 2; i++) begin
         @(negedge fosk);
         exp_e = sb.pop_front();
         n_vec++;
         if ({dout, fe, pe} !== exp_e) begin
            n_err++; $display("FAIL parity9_head%0d: got %h expected %h", i, {dout, fe, pe}, exp_e);
         end
         pop_fifo();
      end
   endtask

   task automatic test_false_start();
      ucsz = 3'b011; upm = 2'b00;
      tick();
      for (int i = 0; i < 5; i++) begin rxd = 1'b0; tick(); end
      rxd = 1'b1;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL false_start_busy: got %b expected 1", busy);
      end
      idle_ticks(20);
      n_vec++;
      if ({busy, level} !== 3'b000) begin
         n_err++; $display("FAIL false_start_idle: busy/level got %b expected 000", {busy, level});
      end
   endtask

   task automatic test_glitch();
      send_frame(9'h055, 8, 0, 0, 1, 3);
      sb.push_back({9'h055, 1'b0, 1'b0});
      @(negedge fosk);
      exp_e = sb.pop_front();
      n_vec++;
      if ({dout, fe, pe} !== exp_e) begin
         n_err++; $display("FAIL glitch_head: got %h expected %h", {dout, fe, pe}, exp_e);
      end
      pop_fifo();
   endtask

   task automatic test_overrun();
      send_frame(9'h011, 8, 0, 0, 1, -1); sb.push_back({9'h011, 2'b00});
      send_frame(9'h022, 8, 0, 0, 1, -1); sb.push_back({9'h022, 2'b00});
      send_frame(9'h033, 8, 0, 0, 1, -1);
      @(negedge fosk);
      n_vec++;
      if ({level, dor} !== 3'b101) begin
         n_err++; $display("FAIL overrun_flags: level/dor got %b expected 101", {level, dor});
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge fosk);
         exp_e = sb.pop_front();
         n_vec++;
         if ({dout, fe, pe} !== exp_e) begin
            n_err++; $display("FAIL overrun_head%0d: got %h expected %h", i, {dout, fe, pe}, exp_e);
         end
         pop_fifo();
         n_vec++;
         if (dor !== 1'b0) begin
            n_err++; $display("FAIL overrun_dor_clear%0d: got %b expected 0", i, dor);
         end
      end
   endtask

   task automatic test_fe_abort();
      send_frame(9'h07F, 8, 0, 0, 0, -1); sb.push_back({9'h07F, 1'b1, 1'b0});
      idle_ticks(32);
      send_frame(9'h001, 8, 0, 0, 1, -1); sb.push_back({9'h001, 2'b00});
      send_frame(9'h002, 8, 0, 0, 1, -1);
      @(negedge fosk);
      n_vec++;
      if ({dout, fe, pe} !== sb[0]) begin
         n_err++; $display("FAIL fe_head: got %h expected %h", {dout, fe, pe}, sb[0]);
      end
      n_vec++;
      if ({level, dor} !== {2'(sb.size()), 1'b1}) begin
         n_err++; $display("FAIL fe_level_dor: got %b expected %b", {level, dor}, {2'(sb.size()), 1'b1});
      end
      tick();
      for (int i = 0; i < 24; i++) begin rxd = 1'b0; tick(); end
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL abort_busy_before: got %b expected 1", busy);
      end
      rxen = 1'b0;
      repeat (2) @(negedge fosk);
      sb.delete();
      n_vec++;
      if ({busy, level, dor} !== 4'b0000) begin
         n_err++; $display("FAIL abort_state: busy/level/dor got %b expected 0000", {busy, level, dor});
      end
      idle_ticks(40);
      rxen = 1'b1;
      idle_ticks(20);
      n_vec++;
      if ({valid, busy} !== 2'b00) begin
         n_err++; $display("FAIL abort_no_push: valid/busy got %b expected 00", {valid, busy});
      end
   endtask

   task automatic test_back_to_back();
      logic p;
      ucsz = 3'b010; upm = 2'b11;
      p = ~(^(7'h3C));
      send_frame(9'h03C, 7, 1, p, 1, -1); sb.push_back({9'h03C, 2'b00});
      ucsz = 3'b000; upm = 2'b00;
      send_frame(9'h015, 5, 0, 0, 1, -1); sb.push_back({9'h015, 2'b00});
      @(negedge fosk);
      n_vec++;
      if (level !== 2'(sb.size())) begin
         n_err++; $display("FAIL b2b_level: got %0d expected %0d", level, sb.size());
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge fosk);
         exp_e = sb.pop_front();
         n_vec++;
         if ({dout, fe, pe} !== exp_e) begin
            n_err++; $display("FAIL b2b_head%0d: got %h expected %h", i, {dout, fe, pe}, exp_e);
         end
         pop_fifo();
      end
      n_vec++;
      if ({valid, dout} !== 10'h000) begin
         n_err++; $display("FAIL b2b_empty: valid/data got %h expected 000", {valid, dout});
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity9();
      test_false_start();
      test_glitch();
      test_overrun();
      test_fe_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/usart_rx_frame_ctrl.md
Name: usart_rx_frame_ctrl

Overview:
Parametrised asynchronous USART receive engine. It combines frame sequencing, oversampled bit recovery with majority voting, parity and frame checking, and a receive FIFO. It replaces the fixed single-buffer receiver FSM. It sits between the baud-rate tick generator and the USART register interface (UDR/UCSRA read path).

Parameters:
DATA_W, 9, maximum data bits per frame; FIFO entry data width.
OVERSAMPLE, 16, sample ticks per bit; even, >= 4.
FIFO_DEPTH, 2, receive FIFO entries; power of 2, >= 2.
LVL_W, 2, width of o_level; equals log2(FIFO_DEPTH)+1.

Ports:
i_fosk  input  1  system clock
i_rst_n  input  1  reset, asynchronous, active-low
i_rxen  input  1  receiver enable
i_rxd  input  1  raw serial line, asynchronous to i_fosk
i_sample_en  input  1  oversample tick, one i_fosk cycle wide
i_ucsz  input  3  data size: 000=5, 001=6, 010=7, 011=8, 111=9; other codes treated as 8
i_upm  input  2  parity: 0x=none, 10=even, 11=odd
i_rd  input  1  pop FIFO head (UDR read strobe)
o_data  output  DATA_W  FIFO head data, LSB = first received bit, unused MSBs zero
o_fe  output  1  frame error of head entry
o_pe  output  1  parity error of head entry
o_dor  output  1  data overrun flag, sticky
o_valid  output  1  FIFO not empty (RXC)
o_level  output  LVL_W  FIFO occupancy
o_busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset: state IDLE; FIFO empty. o_data=0, o_fe=0, o_pe=0, o_dor=0, o_valid=0, o_level=0, o_busy=0. Synchroniser flops reset to 1.
- i_rxd passes through a 2-flop synchroniser clocked by i_fosk (line idle = 1). All line sampling uses the synchronised value, only on cycles where i_sample_en=1.
- Tick counter s counts 0..OVERSAMPLE-1 within each bit. It advances only on i_sample_en.
- Votes are taken at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three and is resolved at s=OVERSAMPLE/2+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when i_rxen=1 on a tick with synchronised rxd=0. That tick is s=0. i_ucsz and i_upm are latched at this moment; changes during a frame have no effect.
  - START: voted value 1 -> false start, go to IDLE with no FIFO write. Voted value 0 -> DATA at the next bit boundary.
  - DATA: shifts in N bits (N from latched ucsz), LSB first. After bit N, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: check the received bit. Even: XOR of data and parity bit must be 0. Odd: it must be 1. A mismatch sets pe for this frame.
  - STOP: only the first stop bit is checked. A voted 0 sets fe. On the vote-resolve tick, go to IDLE and push the entry {data, fe, pe}.
  - The second stop bit (USBS) is not checked. The receiver may detect the next start bit immediately after the first stop bit.
- Push timing: entry is written on the i_fosk edge after the stop-vote tick. o_valid and o_level update on that same edge.
- Pop: i_rd with o_valid=1 removes the head. The next entry appears on the following edge. i_rd while empty is ignored.
- Full FIFO:
  - Push while full with no simultaneous i_rd: frame discarded and o_dor set.
  - Push and pop in the same cycle while full: pop and push both succeed, level unchanged, no overrun.
  - Push and pop in the same cycle while non-full: level unchanged.
- o_dor clears on the first successful pop after it is set, unless a new overrun happens in that same cycle (set wins).
- i_rxen=0: state returns to IDLE on the next edge, the partial frame is discarded, the FIFO is flushed (o_level=0), and o_dor is cleared. Re-enabling waits for a fresh start condition.
- Read pointers and write pointers wrap modulo FIFO_DEPTH. o_level = write count minus read count, range 0..FIFO_DEPTH.
- o_data, o_fe and o_pe are 0 when the FIFO is empty.

Test Plan:
- 8N1, OVERSAMPLE=16: send 0xA5 with ticks every 4 fosk cycles -> one push; o_data=0x0A5, o_fe=0, o_pe=0, o_level=1. i_rd -> o_valid=0.
- 9-bit even parity: send 0x1C3 with the parity bit inverted -> o_data=0x1C3, o_pe=1, o_fe=0. Repeat with correct parity -> o_pe=0.
- False start: drive a 0 pulse lasting 5 ticks from the idle line -> state returns to IDLE, no push, o_level=0.
- Glitch tolerance: send 0x55 (8N1) with a single-tick inversion at the middle vote of bit 3 -> o_data=0x055.
- Overrun, FIFO_DEPTH=2: send 0x11, 0x22, 0x33 without reads -> o_level=2, o_dor=1. Reads return 0x11 then 0x22; o_dor clears after the first read.
- Stop bit held 0 on frame 0x7F (8N1) -> o_fe=1. Then deassert i_rxen mid-way through the next frame -> o_busy=0, o_level=0, o_dor=0, no push.
